// File: rtl/seg_glyph_receiver.sv
// seg_glyph_receiver: receiving end of the seven-segment HELLO/RPOG link.
// Synchronizes the segment bus and its active-low decimal (flash) line, accepts
// a glyph once it has been lit and steady for STABLE_CYCLES samples, decodes it,
// and tracks the glyph stream with a word FSM that pulses on HELLO / RPOG.
// Optional build macro: SEG_ACTIVE_LOW_EN (common-anode pins, inverted at entry).

`default_nettype none

module seg_glyph_receiver #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 131071
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segments,
    input  logic       decimal,
    output logic [2:0] glyph_code,
    output logic       glyph_valid,
    output logic       glyph_err,
    output logic       word_hello,
    output logic       word_rpog,
    output logic [7:0] word_count
);

    localparam int unsigned STAB_MAX = (STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0;
    localparam int unsigned STAB_W   = (STAB_MAX < 2) ? 1 : $clog2(STAB_MAX + 1);
    localparam int unsigned TO_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] CODE_H   = 3'd0;
    localparam logic [2:0] CODE_E   = 3'd1;
    localparam logic [2:0] CODE_L   = 3'd2;
    localparam logic [2:0] CODE_O   = 3'd3;
    localparam logic [2:0] CODE_R   = 3'd4;
    localparam logic [2:0] CODE_P   = 3'd5;
    localparam logic [2:0] CODE_G   = 3'd6;
    localparam logic [2:0] CODE_UNK = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H1   = 3'd1,
        S_HE   = 3'd2,
        S_HEL  = 3'd3,
        S_HELL = 3'd4,
        S_R1   = 3'd5,
        S_RP   = 3'd6,
        S_RPO  = 3'd7
    } word_state_e;

    // Exact-match glyph table; anything else lit is unknown.
    function automatic logic [2:0] decode(input logic [6:0] seg);
        logic [2:0] code;
        case (seg)
            7'b1110100: code = CODE_H;
            7'b1111001: code = CODE_E;
            7'b0111000: code = CODE_L;
            7'b0111111: code = CODE_O;
            7'b1010000: code = CODE_R;
            7'b1110011: code = CODE_P;
            7'b1111101: code = CODE_G;
            default:    code = CODE_UNK;
        endcase
        return code;
    endfunction

    // A mismatching glyph may still start a new word.
    function automatic word_state_e restart(input logic [2:0] code);
        word_state_e st;
        if (code == CODE_H) begin
            st = S_H1;
        end else if (code == CODE_R) begin
            st = S_R1;
        end else begin
            st = S_IDLE;
        end
        return st;
    endfunction

    logic [6:0] seg_pin;
    logic       dp_pin;

`ifdef SEG_ACTIVE_LOW_EN
    // Common-anode display: normalize to active-high segments, active-low flash.
    assign seg_pin = ~segments;
    assign dp_pin  = ~decimal;
`else
    assign seg_pin = segments;
    assign dp_pin  = decimal;
`endif

    logic [6:0]        seg_meta_q, seg_sync_q, seg_prev_q;
    logic              dp_meta_q, dp_sync_q;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              armed_q, armed_d;
    logic              lit;
    logic              accept;
    logic [2:0]        dec_code;

    logic [2:0]        glyph_code_q;
    logic              glyph_valid_q, glyph_err_q;

    word_state_e       state_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              word_hello_q, word_rpog_q;
    logic [7:0]        word_count_q;

    // Two-flop synchronizers; flash line resets to the blank level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_q <= '0;
            seg_sync_q <= '0;
            seg_prev_q <= '0;
            dp_meta_q  <= 1'b1;
            dp_sync_q  <= 1'b1;
        end else begin
            seg_meta_q <= seg_pin;
            seg_sync_q <= seg_meta_q;
            seg_prev_q <= seg_sync_q;
            dp_meta_q  <= dp_pin;
            dp_sync_q  <= dp_meta_q;
        end
    end

    // Stability counting, accept decision and re-arm on blank.
    always_comb begin
        stab_cnt_d = '0;
        armed_d    = armed_q;
        lit        = (dp_sync_q == 1'b0) && (seg_sync_q != 7'd0);
        dec_code   = decode(seg_sync_q);

        if (lit && (seg_sync_q == seg_prev_q)) begin
            if (stab_cnt_q == STAB_W'(STAB_MAX)) begin
                stab_cnt_d = stab_cnt_q;
            end else begin
                stab_cnt_d = stab_cnt_q + STAB_W'(1);
            end
        end

        accept = armed_q && lit && (stab_cnt_d == STAB_W'(STAB_MAX));

        if (accept) begin
            armed_d = 1'b0;
        end else if (!lit) begin
            armed_d = 1'b1;
        end
    end

    // Stability/arm state and registered glyph outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt_q    <= '0;
            armed_q       <= 1'b1;
            glyph_code_q  <= CODE_H;
            glyph_valid_q <= 1'b0;
            glyph_err_q   <= 1'b0;
        end else begin
            stab_cnt_q    <= stab_cnt_d;
            armed_q       <= armed_d;
            glyph_valid_q <= accept;
            glyph_err_q   <= accept && (dec_code == CODE_UNK);
            if (accept) begin
                glyph_code_q <= dec_code;
            end
        end
    end

    // Word FSM with inactivity timeout; a glyph on the timeout cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            to_cnt_q     <= '0;
            word_hello_q <= 1'b0;
            word_rpog_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            word_hello_q <= 1'b0;
            word_rpog_q  <= 1'b0;

            if (glyph_valid_q) begin
                to_cnt_q <= '0;
                case (state_q)
                    S_IDLE: state_q <= restart(glyph_code_q);
                    S_H1:   state_q <= (glyph_code_q == CODE_E) ? S_HE   : restart(glyph_code_q);
                    S_HE:   state_q <= (glyph_code_q == CODE_L) ? S_HEL  : restart(glyph_code_q);
                    S_HEL:  state_q <= (glyph_code_q == CODE_L) ? S_HELL : restart(glyph_code_q);
                    S_HELL: begin
                        if (glyph_code_q == CODE_O) begin
                            state_q      <= S_IDLE;
                            word_hello_q <= 1'b1;
                            word_count_q <= word_count_q + 8'd1;
                        end else begin
                            state_q <= restart(glyph_code_q);
                        end
                    end
                    S_R1:   state_q <= (glyph_code_q == CODE_P) ? S_RP  : restart(glyph_code_q);
                    S_RP:   state_q <= (glyph_code_q == CODE_O) ? S_RPO : restart(glyph_code_q);
                    S_RPO: begin
                        if (glyph_code_q == CODE_G) begin
                            state_q      <= S_IDLE;
                            word_rpog_q  <= 1'b1;
                            word_count_q <= word_count_q + 8'd1;
                        end else begin
                            state_q <= restart(glyph_code_q);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE) begin
                if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q  <= S_IDLE;
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign glyph_code  = glyph_code_q;
    assign glyph_valid = glyph_valid_q;
    assign glyph_err   = glyph_err_q;
    assign word_hello  = word_hello_q;
    assign word_rpog   = word_rpog_q;
    assign word_count  = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_glyph_receiver.sv
// Directed bench for seg_glyph_receiver: reset, latency, HELLO, RPOG with an
// unknown glyph, stability/re-arm, timeout and word_count wrap.

`timescale 1ns/1ps

module tb_seg_glyph_receiver;

    localparam int unsigned STAB = 4;
    localparam int unsigned TO   = 100;

    localparam logic [6:0] G_H = 7'b1110100;
    localparam logic [6:0] G_E = 7'b1111001;
    localparam logic [6:0] G_L = 7'b0111000;
    localparam logic [6:0] G_O = 7'b0111111;
    localparam logic [6:0] G_R = 7'b1010000;
    localparam logic [6:0] G_P = 7'b1110011;
    localparam logic [6:0] G_G = 7'b1111101;
    localparam logic [6:0] G_X = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] segments;
    logic       decimal;
    logic [2:0] glyph_code;
    logic       glyph_valid;
    logic       glyph_err;
    logic       word_hello;
    logic       word_rpog;
    logic [7:0] word_count;

    int tests = 0;
    int fails = 0;

    int n_valid = 0;
    int n_err   = 0;
    int n_hello = 0;
    int n_rpog  = 0;
    int codes [0:2047];

    always #5 clk = ~clk;

    seg_glyph_receiver #(
        .STABLE_CYCLES (STAB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .segments   (segments),
        .decimal    (decimal),
        .glyph_code (glyph_code),
        .glyph_valid(glyph_valid),
        .glyph_err  (glyph_err),
        .word_hello (word_hello),
        .word_rpog  (word_rpog),
        .word_count (word_count)
    );

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (glyph_valid) begin
            if (n_valid < 2048) codes[n_valid] = int'(glyph_code);
            n_valid++;
        end
        if (glyph_err)  n_err++;
        if (word_hello) n_hello++;
        if (word_rpog)  n_rpog++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic glyph(input logic [6:0] p, input int hold, input int gap);
        segments = p;
        decimal  = 1'b0;
        repeat (hold) @(negedge clk);
        segments = 7'd0;
        decimal  = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    int b, e, h, r;

    initial begin
        rst      = 1'b1;
        segments = 7'd0;
        decimal  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_code",  int'(glyph_code), 0);
        chk("rst_valid", int'(glyph_valid), 0);
        chk("rst_count", int'(word_count), 0);
        chk("rst_hello", int'(word_hello), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // HELLO, with exact latency on the first glyph
        b = n_valid; h = n_hello;
        segments = G_H; decimal = 1'b0;
        repeat (5) @(negedge clk);
        #1 chk("lat_early", int'(glyph_valid), 0);
        @(negedge clk);
        #1 chk("lat_exact", int'(glyph_valid), 1);
        chk("lat_code", int'(glyph_code), 0);
        repeat (14) @(negedge clk);
        segments = 7'd0; decimal = 1'b1;
        repeat (5) @(negedge clk);
        glyph(G_E, 20, 5);
        glyph(G_L, 20, 5);
        glyph(G_L, 20, 5);
        glyph(G_O, 20, 5);
        chk("hello_nvalid", n_valid - b, 5);
        chk("hello_c0", codes[b],   0);
        chk("hello_c1", codes[b+1], 1);
        chk("hello_c2", codes[b+2], 2);
        chk("hello_c3", codes[b+3], 2);
        chk("hello_c4", codes[b+4], 3);
        chk("hello_pulse", n_hello - h, 1);
        chk("hello_count", int'(word_count), 1);

        // RPOG interrupted by an unknown glyph
        b = n_valid; e = n_err; r = n_rpog; h = n_hello;
        glyph(G_R, 20, 5);
        glyph(G_P, 20, 5);
        glyph(G_X, 20, 5);
        glyph(G_R, 20, 5);
        glyph(G_P, 20, 5);
        glyph(G_O, 20, 5);
        glyph(G_G, 20, 5);
        chk("rpog_nvalid", n_valid - b, 7);
        chk("rpog_err", n_err - e, 1);
        chk("rpog_xcode", codes[b+2], 7);
        chk("rpog_gcode", codes[b+6], 6);
        chk("rpog_pulse", n_rpog - r, 1);
        chk("rpog_nohello", n_hello - h, 0);
        chk("rpog_count", int'(word_count), 2);

        // Toggling faster than the stability window never accepts
        b = n_valid;
        decimal = 1'b0;
        for (int i = 0; i < 20; i++) begin
            segments = (i % 2 == 0) ? G_L : G_O;
            repeat (2) @(negedge clk);
        end
        segments = 7'd0; decimal = 1'b1;
        repeat (5) @(negedge clk);
        chk("toggle_none", n_valid - b, 0);

        // A held glyph is accepted exactly once
        b = n_valid;
        glyph(G_L, 1000, 5);
        chk("hold_once", n_valid - b, 1);
        chk("hold_code", codes[b], 2);

        // Timeout abandons a partial word
        b = n_valid; h = n_hello;
        glyph(G_H, 20, 5);
        glyph(G_E, 20, 150);
        glyph(G_L, 20, 5);
        glyph(G_L, 20, 5);
        glyph(G_O, 20, 5);
        chk("to_nvalid", n_valid - b, 5);
        chk("to_nohello", n_hello - h, 0);
        chk("to_count", int'(word_count), 2);

        // Asynchronous reset mid-glyph
        segments = G_H; decimal = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_code",  int'(glyph_code), 0);
        chk("arst_count", int'(word_count), 0);
        chk("arst_valid", int'(glyph_valid), 0);
        chk("arst_err",   int'(glyph_err), 0);
        chk("arst_hello", int'(word_hello), 0);
        chk("arst_rpog",  int'(word_rpog), 0);
        @(negedge clk);
        segments = 7'd0; decimal = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b = n_valid;
        repeat (10) @(negedge clk);
        chk("arst_nospur", n_valid - b, 0);

        // 256 HELLO words wrap word_count
        h = n_hello;
        for (int w = 0; w < 256; w++) begin
            glyph(G_H, 8, 3);
            glyph(G_E, 8, 3);
            glyph(G_L, 8, 3);
            glyph(G_L, 8, 3);
            glyph(G_O, 8, 3);
            if (w == 254) chk("wrap_255", int'(word_count), 255);
        end
        chk("wrap_pulses", n_hello - h, 256);
        chk("wrap_zero", int'(word_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_glyph_receiver.md
Name: seg_glyph_receiver

Overview:
Receiving end of the seven-segment "HELLO"/"RPOG" display link. Samples a segments[6:0] bus and its active-low decimal (flash) line, waits for each lit glyph to settle, and decodes the glyph to a 3-bit code. It tracks the glyph sequence with a word-matching FSM and pulses when a full HELLO or RPOG word has been received. Used as an on-chip loopback checker and as a standalone display-snooping block.

Parameters:
STABLE_CYCLES, 4, consecutive identical lit samples required before a glyph is accepted (min 1)
TIMEOUT_CYCLES, 131071, clocks with no accepted glyph before a partial word is abandoned (min 1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
segments  input  7  segment pattern from display driver, bit0=a .. bit6=g, 1=lit
decimal  input  1  decimal-point line, active low: 0 = display lit (flash on)
glyph_code  output  3  last accepted glyph: H=0 E=1 L=2 O=3 R=4 P=5 G=6 unknown=7
glyph_valid  output  1  one-cycle pulse when glyph_code updates
glyph_err  output  1  one-cycle pulse, coincident with glyph_valid, when code=7
word_hello  output  1  one-cycle pulse on completion of H,E,L,L,O
word_rpog  output  1  one-cycle pulse on completion of R,P,O,G
word_count  output  8  number of completed words (either kind), wraps 255->0

Behaviour:
- Reset is an already-decided fact: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: glyph_code=0, all pulses=0, word_count=0, FSM=IDLE, armed=1, stability and timeout counters=0. Reset asserted mid-glyph or mid-word discards everything and applies these values immediately.
- Input sync: segments and decimal each pass through a 2-flop synchronizer. All further logic uses the synced values (s_seg, s_dp).
- lit = (s_dp==0) && (s_seg!=0). blank = !lit.
- Stability: on lit with s_seg equal to the previous cycle's s_seg, stab_cnt increments (saturating). On a change or on blank, stab_cnt resets to 0.
- Accept: when armed, lit, and stab_cnt reaches STABLE_CYCLES-1:
  - glyph_valid pulses the next cycle with the decoded code.
  - armed clears.
  - Latency from a stable pattern at the pins to glyph_valid is 2 (sync) + STABLE_CYCLES clocks.
- Re-arm: armed sets after at least one blank cycle. Repeated glyphs (L,L) therefore require a blank gap between them. A glyph held lit indefinitely is accepted once.
- Decode (exact match only): 1110100=H, 1111001=E, 0111000=L, 0111111=O, 1010000=R, 1110011=P, 1111101=G. Any other non-zero pattern gives code 7 and glyph_err.
- Word FSM states: IDLE, H1, HE, HEL, HELL, R1, RP, RPO. It advances only on glyph_valid.
  - Expected next glyph advances the FSM.
  - HELL+O pulses word_hello and goes to IDLE.
  - RPO+G pulses word_rpog and goes to IDLE.
  - On a mismatch: the glyph is H -> H1; the glyph is R -> R1; otherwise -> IDLE. This includes code 7.
- Word pulses occur in the cycle after the glyph_valid that completes the word. word_count increments in that same cycle.
- Timeout: while FSM != IDLE, to_cnt counts clocks and clears on each glyph_valid. Reaching TIMEOUT_CYCLES forces IDLE with no pulse. to_cnt is held at 0 while the FSM is in IDLE.
- Simultaneous events: glyph_valid on the timeout cycle takes precedence. The glyph is processed and the timeout is ignored.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: segments and decimal are inverted before the synchronizers, for a common-anode display. Lit then requires decimal==1 at the pin and a segment pin at 0. All decode tables are unchanged after inversion.
- Undefined: pins are used as described above.

Test Plan:
- Reset check: assert rst asynchronously mid-glyph -> all outputs 0 and word_count=0 within the same cycle. After release, no spurious glyph_valid.
- HELLO word: drive H,E,L,L,O with decimal=0 for 20 clocks each, separated by 5 blank clocks (decimal=1) -> 5 glyph_valid with codes 0,1,2,2,3; word_hello pulses once; word_count=1.
- RPOG word with interruption: R,P,X(0000001),R,P,O,G -> glyph_err once with code 7; word_rpog once after G; word_count increments by 1.
- Stability and re-arm: pattern toggling every 2 clocks with STABLE_CYCLES=4 -> no glyph_valid. L held for 1000 clocks with no blank -> exactly one glyph_valid.
- Timeout: H,E, then idle for TIMEOUT_CYCLES=100 (override), then L,L,O -> no word_hello.
- Wrap: 256 HELLO words -> word_count returns to 0; word_hello pulse count is 256.
